// File: rtl/ms_delay_pipe.sv
// Purpose: WIDTH-bit, DEPTH-stage stallable delay line with per-stage valid bits,
//          synchronous flush and optional occupancy count (build with DLY_OCC_EN).
// Latency: DEPTH enabled cycles; stall cycles add one-for-one. No backpressure is
//          produced: when en=0 the input beat is ignored, so the source must hold it.
module ms_delay_pipe #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int OCCW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [OCCW-1:0]  occ
);

    // Stage k holds {v[k], d[k]}; stage 0 is the entry, stage DEPTH-1 drives the outputs.
    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];

    // Shift register: reset clears everything, flush clears only valid bits,
    // en shifts one place, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                d[k] <= '0;
            end
        end else if (flush) begin
            // Data is left in place so invalid stages stay deterministic.
            v <= '0;
        end else if (en) begin
            v[0] <= in_valid;
            d[0] <= in_data;
            for (int k = DEPTH - 1; k >= 1; k--) begin
                v[k] <= v[k-1];
                d[k] <= d[k-1];
            end
        end
    end

    // Outputs come straight from the last stage register; no input-to-output path.
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

`ifdef DLY_OCC_EN
    logic [OCCW-1:0] occ_q;

    // Occupancy tracks popcount(v): one beat may enter and one may leave per
    // advance, so the count stays within 0..DEPTH without saturation logic.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            occ_q <= '0;
        end else if (en) begin
            occ_q <= occ_q + OCCW'(in_valid) - OCCW'(v[DEPTH-1]);
        end
    end

    assign occ = occ_q;
`else
    // Counter not built; occupancy reads as empty.
    assign occ = '0;
`endif

endmodule

// File: tb/tb_ms_delay_pipe.sv
// Bench for ms_delay_pipe (WIDTH=8, DEPTH=4): history-based model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
// Occupancy expectations follow DLY_OCC_EN; without it occ must always be 0.
module tb_ms_delay_pipe;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int OW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst, en, flush, in_valid;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [OW-1:0] occ;

    int checks = 0;
    int errors = 0;

    ms_delay_pipe #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .occ       (occ)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: history of every beat accepted by an advance since reset. The
    // output is the beat accepted D advances ago; a flush invalidates all
    // beats recorded so far but keeps their data.
    logic [W-1:0] hd[$];
    bit           hv[$];
    bit           live = 0;

    always @(posedge clk) begin
        if (rst) begin
            hd.delete();
            hv.delete();
            for (int i = 0; i < D; i++) begin
                hd.push_back('0);
                hv.push_back(1'b0);
            end
            live = 1;
        end else if (live) begin
            if (flush) begin
                for (int i = 0; i < hv.size(); i++) hv[i] = 1'b0;
            end else if (en) begin
                hd.push_back(in_data);
                hv.push_back(in_valid);
            end
        end
    end

    function automatic int model_occ();
        int n = 0;
`ifdef DLY_OCC_EN
        for (int i = hv.size() - D; i < hv.size(); i++) n += int'(hv[i]);
`endif
        return n;
    endfunction

    // Compare process: outputs against the model, away from the active edge.
    always @(negedge clk) begin
        if (live) begin
            chk("model_valid", out_valid, hv[hv.size() - D]);
            chk("model_data",  out_data,  hd[hd.size() - D]);
            chk("model_occ",   occ,       model_occ());
        end
    end

    // One clock: apply inputs, take the edge, settle just after it.
    task automatic cyc(input logic r, input logic f, input logic e,
                       input logic iv, input logic [W-1:0] dd);
        rst = r; flush = f; en = e; in_valid = iv; in_data = dd;
        @(posedge clk);
        #1;
    endtask

    function automatic int occ_exp(input int n);
`ifdef DLY_OCC_EN
        return n;
`else
        return 0;
`endif
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; en = 1'b1; in_valid = 1'b1; in_data = 8'hFF;

        // 1. Reset with busy inputs, then first cycle after it.
        for (int i = 0; i < 2; i++) begin
            cyc(1, 0, 1, 1, 8'hFF);
            chk("rst_valid", out_valid, 0);
            chk("rst_data",  out_data,  8'h00);
            chk("rst_occ",   occ,       0);
        end
        cyc(0, 0, 1, 0, 8'h00);
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_data",  out_data,  8'h00);
        chk("post_rst_occ",   occ,       0);

        // 2. Latency: single beat A5, visible during cycle 4 only.
        cyc(0, 0, 1, 1, 8'hA5);
        for (int c = 1; c <= 6; c++) begin
            chk("lat_valid", out_valid, (c == 4) ? 1 : 0);
            if (c == 4) chk("lat_data", out_data, 8'hA5);
            chk("lat_occ", occ, occ_exp((c <= 4) ? 1 : 0));
            cyc(0, 0, 1, 0, 8'h00);
        end

        // 3. Stall: 11,22,33 then three stalled cycles presenting EE (ignored).
        cyc(0, 0, 1, 1, 8'h11);
        cyc(0, 0, 1, 1, 8'h22);
        cyc(0, 0, 1, 1, 8'h33);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 8'hEE);
            chk("stall_valid", out_valid, 0);
            chk("stall_occ",   occ,       occ_exp(3));
        end
        cyc(0, 0, 1, 0, 8'h00);
        chk("stall_out0", {out_valid, out_data}, {1'b1, 8'h11});
        cyc(0, 0, 1, 0, 8'h00);
        chk("stall_out1", {out_valid, out_data}, {1'b1, 8'h22});
        cyc(0, 0, 1, 0, 8'h00);
        chk("stall_out2", {out_valid, out_data}, {1'b1, 8'h33});
        chk("stall_occ_end", occ, occ_exp(1));
        cyc(0, 0, 1, 0, 8'h00);
        chk("stall_drain", out_valid, 0);

        // 4. Flush mid-stream with a full pipe; 77 must never emerge.
        for (int i = 1; i <= 4; i++) cyc(0, 0, 1, 1, 8'h40 + 8'(i));
        chk("full_out", {out_valid, out_data}, {1'b1, 8'h41});
        chk("full_occ", occ, occ_exp(4));
        cyc(0, 1, 1, 1, 8'h77);
        chk("flush_valid", out_valid, 0);
        chk("flush_occ",   occ,       0);
        chk("flush_data_kept", out_data, 8'h41);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 1, 0, 8'h00);
            chk("flush_no77", out_valid, 0);
        end

        // 5. Steady-state full stream of incrementing data.
        for (int i = 0; i < 12; i++) begin
            cyc(0, 0, 1, 1, 8'h80 + 8'(i));
            if (i >= 3) begin
                chk("steady_out", {out_valid, out_data}, {1'b1, 8'h80 + 8'(i - 3)});
                chk("steady_occ", occ, occ_exp(4));
            end
        end

        // 6. Reset beats flush and stall on a full pipe.
        cyc(1, 1, 0, 1, 8'h5A);
        chk("rstprio_valid", out_valid, 0);
        chk("rstprio_data",  out_data,  8'h00);
        chk("rstprio_occ",   occ,       0);
        cyc(0, 0, 1, 0, 8'h00);
        chk("rstprio_after", {out_valid, out_data}, {1'b0, 8'h00});

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ms_delay_pipe.md
Name: ms_delay_pipe

Overview:
- Parametrised successor to the single-bit master-slave flip-flop: a WIDTH-bit, DEPTH-stage registered delay line.
- Each stage carries a valid bit. The line supports a global advance enable (stall), a synchronous flush, and optional occupancy tracking.
- Used wherever the lab designs need a retimed, stallable data path between clocked blocks. Everything is on one clock edge, with no inverted-clock slave stage.

Parameters:
- WIDTH, 8, data bits per stage (>=1).
- DEPTH, 4, number of pipeline stages (>=1). This is also the latency in advancing cycles.
- OCCW, $clog2(DEPTH+1), width of the occupancy count (derived localparam, not overridable).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  advance enable; 1 = every stage shifts one place, 0 = all stages hold.
- flush  input  1  synchronous clear of all valid bits.
- in_valid  input  1  input beat qualifier.
- in_data  input  WIDTH  input beat data.
- out_valid  output  1  valid bit of the last stage (stage DEPTH-1).
- out_data  output  WIDTH  data of the last stage.
- occ  output  OCCW  number of stages currently holding a valid beat (see Optional Feature).

Behaviour:
- Storage: stage[k] = {v[k], d[k]} for k = 0..DEPTH-1. Outputs are stage DEPTH-1 directly, registered, with no combinational path from the inputs.
- Update priority per posedge, highest first:
  - rst=1: all v[k]=0, all d[k]=0, occ=0. Overrides en and flush. Mid-stream reset discards all beats in one cycle.
  - flush=1: all v[k]=0; d[k] unchanged. The input beat presented in the same cycle is dropped, even if en=1. occ=0.
  - en=1: stage[0] <= {in_valid, in_data}; stage[k] <= stage[k-1] for k>=1. The beat in stage DEPTH-1 leaves the pipe and is not retained.
  - en=0: all stages hold; in_valid/in_data are ignored (the beat is lost; the upstream source must hold it).
- Data capture: d[0] loads in_data whenever en=1, regardless of in_valid. Data of invalid stages is unspecified to consumers, but is deterministic for the bench.
- Latency: a beat presented at cycle t with en=1 appears on out_* after exactly DEPTH further en=1 cycles. Stall cycles extend the latency one-for-one. Ordering is strictly preserved.
- DEPTH=1: single register stage; out_* follows the input one enabled cycle later.
- Reset values: out_valid=0, out_data=0, occ=0.
- No backpressure output. The block never blocks; overflow is impossible, since one beat enters and one leaves per advance.

Optional Feature:
- Macro: DLY_OCC_EN.
- Defined: occ is a registered counter equal to the popcount of v[].
  - On an en=1 cycle without flush: occ_next = occ + in_valid - v[DEPTH-1].
  - On en=0: occ holds. On flush or rst: occ becomes 0.
  - occ never exceeds DEPTH and never underflows.
  - Simultaneous entry and exit of valid beats leaves occ unchanged.
- Not defined: no counter logic is built; occ is driven constant 0.

Test Plan:
1. Reset: assert rst for 2 cycles with en=1, in_valid=1, in_data=8'hFF -> out_valid=0, out_data=8'h00, occ=0 throughout reset and on the first cycle after it.
2. Latency (WIDTH=8, DEPTH=4): en=1 continuously, single beat in_valid=1, in_data=8'hA5 at cycle 0, then in_valid=0 -> out_valid=1, out_data=8'hA5 at cycle 4 only. With DLY_OCC_EN, occ reads 1 over cycles 1..4 and 0 after.
3. Stall: send beats 8'h11, 8'h22, 8'h33 on consecutive cycles, then drop en for 3 cycles, then raise it -> outputs freeze during the stall, and 11, 22, 33 emerge in order on consecutive enabled cycles. Total latency = 4 + 3 for each beat.
4. Flush mid-stream: fill all 4 stages with valid beats (occ=4), then flush=1 together with en=1 and in_valid=1, in_data=8'h77 -> next cycle out_valid=0, occ=0. 8'h77 never appears at the output.
5. Steady-state full: in_valid=1 every cycle with an incrementing counter as in_data -> after 4 cycles out_valid stays 1, out_data = in_data delayed by 4, occ stays 4.
6. Reset priority: with a full pipe, assert rst and flush together, en=0 -> all outputs 0 next cycle. Build without DLY_OCC_EN and confirm occ is 0 in every scenario.
